// File: rtl/demux_rr_dispatch_if.sv
// Word-stream bus between the upstream source, the dispatcher, and the 4-way demux consumers.
// Upstream side: a word moves when in_valid & in_ready are both high at a rising edge.
// Downstream side: a/s stay stable while out_valid is high, and the word moves when ch_ready[s] is high.
interface demux_rr_dispatch_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic [N-1:0] a;
    logic [1:0]   s;
    logic         out_valid;
    logic [3:0]   ch_ready;

    modport master (
        output in_valid, in_data, ch_ready,
        input  in_ready, a, s, out_valid
    );

    modport slave (
        input  in_valid, in_data, ch_ready,
        output in_ready, a, s, out_valid
    );
endinterface

// File: rtl/demux_rr_dispatch.sv
// Registers an upstream word stream onto the demux a/s inputs.
// Channels are picked round-robin or fixed, and each channel has a saturating delivery counter.
module demux_rr_dispatch #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_rr_dispatch_if.slave    bus,
    input  logic                  mode_fixed,
    input  logic [1:0]            fixed_sel,
    input  logic                  cnt_clr,
    output logic [CW-1:0]         cnt0,
    output logic [CW-1:0]         cnt1,
    output logic [CW-1:0]         cnt2,
    output logic [CW-1:0]         cnt3
);
    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q;
    logic [1:0]    s_q;
    logic [1:0]    ptr_q;
    logic [CW-1:0] cnt_q [4];
    logic          accept;
    logic          load;
    logic          in_ready;

    // out_valid is the state register itself, so the FSM state is visible on the bus
    assign bus.out_valid = (state_q == HOLD);
    assign bus.a         = a_q;
    assign bus.s         = s_q;
    assign bus.in_ready  = in_ready;

    assign accept   = (state_q == HOLD) & bus.ch_ready[s_q];
    assign in_ready = ~rst & ((state_q == EMPTY) | accept);
    assign load     = bus.in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load) state_d = HOLD;
            HOLD:  if (accept && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            a_q     <= '0;
            s_q     <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q <= bus.in_data;
                if (mode_fixed) begin
                    s_q <= fixed_sel;
                end else begin
                    s_q   <= ptr_q;
                    ptr_q <= ptr_q + 2'd1;
                end
            end
        end
    end

    // Clear wins over a same-cycle delivery; that delivery is not counted
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else if (accept && (cnt_q[s_q] != {CW{1'b1}})) begin
            cnt_q[s_q] <= cnt_q[s_q] + CW'(1);
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed bench for demux_rr_dispatch, with a second instance (CW=2) for counter saturation.
module tb_demux_rr_dispatch;
    logic       clk;
    logic       rst;
    logic       mode_fixed;
    logic [1:0] fixed_sel;
    logic       cnt_clr;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
    logic [1:0] c2_0, c2_1, c2_2, c2_3;
    int         errors;
    int         checks;

    demux_rr_dispatch_if #(.N(8)) bus  ();
    demux_rr_dispatch_if #(.N(8)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_data  = bus.in_data;
    assign bus2.ch_ready = bus.ch_ready;

    demux_rr_dispatch #(.N(8), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .mode_fixed(mode_fixed), .fixed_sel(fixed_sel),
        .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    demux_rr_dispatch #(.N(8), .CW(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .mode_fixed(mode_fixed), .fixed_sel(fixed_sel),
        .cnt_clr(cnt_clr), .cnt0(c2_0), .cnt1(c2_1), .cnt2(c2_2), .cnt3(c2_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00; cnt_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.ch_ready = 4'hF;
        mode_fixed = 1'b0; fixed_sel = 2'd0; cnt_clr = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        step();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_a", {24'd0, bus.a}, 32'd0);
        chk("reset_s", {30'd0, bus.s}, 32'd0);
        chk("reset_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'd0);
    endtask

    task automatic test_rr_stream();
        logic [7:0] w [5];
        w[0] = 8'hD5; w[1] = 8'hAA; w[2] = 8'hF0; w[3] = 8'h0F; w[4] = 8'h33;
        do_reset();
        mode_fixed = 1'b0; bus.ch_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = w[i];
            @(negedge clk);
            chk("rr_in_ready", {31'd0, bus.in_ready}, 32'd1);
            step();
            chk("rr_a", {24'd0, bus.a}, {24'd0, w[i]});
            chk("rr_s", {30'd0, bus.s}, i % 4);
            chk("rr_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("rr_drained", {31'd0, bus.out_valid}, 32'd0);
        chk("rr_cnts", {cnt0, cnt1, cnt2, cnt3}, {8'd2, 8'd1, 8'd1, 8'd1});
    endtask

    task automatic test_stall();
        do_reset();
        mode_fixed = 1'b0; bus.ch_ready = 4'b1101;
        bus.in_valid = 1'b1; bus.in_data = 8'h11;
        step();
        chk("stall_s0", {30'd0, bus.s}, 32'd0);
        chk("stall_a0", {24'd0, bus.a}, 32'h11);
        bus.in_data = 8'h22;
        step();
        chk("stall_s1", {30'd0, bus.s}, 32'd1);
        chk("stall_cnt0", {24'd0, cnt0}, 32'd1);
        bus.in_data = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            step();
            chk("stall_hold", {22'd0, bus.out_valid, bus.s, bus.a}, {22'd0, 1'b1, 2'd1, 8'h22});
        end
        bus.ch_ready = 4'b1111;
        @(negedge clk);
        chk("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("stall_next", {22'd0, bus.out_valid, bus.s, bus.a}, {22'd0, 1'b1, 2'd2, 8'h33});
        chk("stall_cnt1", {24'd0, cnt1}, 32'd1);
        step();
        chk("stall_cnt2", {24'd0, cnt2}, 32'd1);
        chk("stall_empty", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic test_fixed();
        do_reset();
        mode_fixed = 1'b1; fixed_sel = 2'b11; bus.ch_ready = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h40 + i);
            step();
            chk("fixed_s", {30'd0, bus.s}, 32'd3);
        end
        bus.in_valid = 1'b0;
        step();
        chk("fixed_cnt3", {24'd0, cnt3}, 32'd4);
        mode_fixed = 1'b0; bus.ch_ready = 4'b1111;
        bus.in_valid = 1'b1; bus.in_data = 8'h99;
        step();
        bus.in_valid = 1'b0;
        chk("fixed_ptr_kept", {30'd0, bus.s}, 32'd0);
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        mode_fixed = 1'b1; fixed_sel = 2'd1; bus.ch_ready = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("sat_cw2_cnt1", {30'd0, c2_1}, 32'd3);
        chk("sat_cw8_cnt1", {24'd0, cnt1}, 32'd5);
        step();
        chk("sat_stays", {30'd0, c2_1}, 32'd3);
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        step();
        bus.in_valid = 1'b0; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_cw2", {30'd0, c2_1}, 32'd0);
        chk("clr_cw8", {24'd0, cnt1}, 32'd0);
        chk("clr_accepted", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode_fixed = 1'b1; fixed_sel = 2'd0; bus.ch_ready = 4'b1011;
        bus.in_valid = 1'b1; bus.in_data = 8'h3C;
        step();
        fixed_sel = 2'd2; bus.in_data = 8'h5A;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("mid_hold", {21'd0, bus.out_valid, cnt0, bus.s}, {21'd0, 1'b1, 8'd1, 2'd2});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_cleared", {21'd0, bus.out_valid, bus.a, bus.s}, 32'd0);
        chk("mid_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'd0);
        mode_fixed = 1'b0; bus.ch_ready = 4'b1111;
        bus.in_valid = 1'b1; bus.in_data = 8'h61;
        step();
        bus.in_valid = 1'b0;
        chk("mid_next_s", {30'd0, bus.s}, 32'd0);
        step();
    endtask

    task automatic test_hold_stable();
        do_reset();
        mode_fixed = 1'b0; bus.ch_ready = 4'b1101;
        bus.in_valid = 1'b1; bus.in_data = 8'hA1;
        step();
        bus.in_data = 8'hB2;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode_fixed = ~mode_fixed; fixed_sel = 2'(i + 2);
            step();
            chk("stable_s", {30'd0, bus.s}, 32'd1);
        end
        bus.ch_ready = 4'b1111;
        step();
        chk("stable_done", {31'd0, bus.out_valid}, 32'd0);
        chk("stable_cnt1", {24'd0, cnt1}, 32'd1);
    endtask

    initial begin
        errors = 0; checks = 0;
        test_reset();
        test_rr_stream();
        test_stall();
        test_fixed();
        test_saturate();
        test_reset_mid();
        test_hold_stable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
